// File: rtl/tlp_pkt_fifo.sv
// tlp_pkt_fifo: packet-aware TLP FIFO holding header+payload beats with SOP/EOP framing.
// Store-and-forward builds each TLP behind a speculative write pointer and publishes it
// on EOP; cut-through publishes every beat as it is written. Producer abort, oversize
// recovery (discard until EOP) and framing errors are reported as one-cycle pulses.
module tlp_pkt_fifo #(
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int TLP_DATA_WIDTH = 128,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter bit STORE_FWD      = 1'b1,
  parameter int AFULL_THRESH   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TLP_DATA_WIDTH-1:0] in_data,
  input  logic [TLP_HDR_WIDTH-1:0]  in_hdr,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic                      in_abort,
  output logic                      in_ready,
  output logic [TLP_DATA_WIDTH-1:0] out_data,
  output logic [TLP_HDR_WIDTH-1:0]  out_hdr,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH:0]       level,
  output logic [ADDR_WIDTH:0]       pkt_count,
  output logic                      almost_full,
  output logic                      drop_pulse,
  output logic                      err_pulse
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int EW = TLP_HDR_WIDTH + TLP_DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PKT     = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_t;

  wr_state_t state_r, state_nxt_s;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [PW-1:0] wr_spec_r, wr_cmt_r, rd_r;
  logic [PW-1:0] wr_spec_nxt_s, wr_cmt_nxt_s;
  logic [PW-1:0] level_s;
  logic [PW-1:0] pkt_count_r;

  logic                  full_s, accept_s, rd_fire_s, oversize_s, abort_s;
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic                  commit_s, drop_s, err_s, pop_eop_s;
  logic                  drop_pulse_r, err_pulse_r;

  logic [EW-1:0] mem_r [DEPTH];
  logic [EW-1:0] head_s;

  assign level_s  = wr_spec_r - rd_r;
  assign full_s   = (level_s == PW'(DEPTH));
  // The discard state never stores anything, so it keeps accepting to flush the bad TLP.
  assign in_ready = (!full_s || (state_r == ST_DISCARD)) && !rst;
  assign accept_s = in_valid && in_ready;
  assign abort_s  = STORE_FWD && in_abort && in_eop;

  // A partial TLP that would fill the whole FIFO with nothing committed ahead of it can never
  // be released, so it is dropped rather than left to deadlock the producer.
  assign oversize_s = STORE_FWD && (state_r == ST_PKT) && !in_sop &&
                      ((level_s + PW'(1)) == PW'(DEPTH)) && (wr_cmt_r == rd_r);

  assign head_s    = mem_r[rd_r[ADDR_WIDTH-1:0]];
  assign out_valid = (rd_r != wr_cmt_r);
  assign out_hdr   = head_s[EW-1 -: TLP_HDR_WIDTH];
  assign out_data  = head_s[TLP_DATA_WIDTH+1 : 2];
  assign out_sop   = head_s[1];
  assign out_eop   = head_s[0];
  assign rd_fire_s = out_valid && out_ready;
  assign pop_eop_s = rd_fire_s && out_eop;

  assign level       = level_s;
  assign pkt_count   = pkt_count_r;
  assign almost_full = (level_s >= PW'(AFULL_THRESH));
  assign drop_pulse  = drop_pulse_r;
  assign err_pulse   = err_pulse_r;

  // Write-side framing state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next framing state from the accepted beat.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (in_sop && !in_eop) begin
            state_nxt_s = ST_PKT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PKT: begin
          if (oversize_s) begin
            state_nxt_s = in_eop ? ST_IDLE : ST_DISCARD;
          end else if (in_eop) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_PKT;
          end
        end
        ST_DISCARD: begin
          if (in_eop) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DISCARD;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Write enable, write address, pointer updates and event flags for the accepted beat.
  always_comb begin
    wr_en_s       = 1'b0;
    wr_addr_s     = wr_spec_r[ADDR_WIDTH-1:0];
    wr_spec_nxt_s = wr_spec_r;
    wr_cmt_nxt_s  = wr_cmt_r;
    commit_s      = 1'b0;
    drop_s        = 1'b0;
    err_s         = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!in_sop) begin
            err_s = 1'b1;
          end else if (abort_s) begin
            drop_s = 1'b1;
          end else begin
            wr_en_s       = 1'b1;
            wr_spec_nxt_s = wr_spec_r + PW'(1);
            commit_s      = in_eop;
          end
        end
        ST_PKT: begin
          if (in_sop && STORE_FWD) begin
            // Restart: throw away the partial TLP and begin the new one at the commit point.
            err_s         = 1'b1;
            wr_spec_nxt_s = wr_cmt_r;
            if (abort_s) begin
              drop_s = 1'b1;
            end else begin
              wr_en_s       = 1'b1;
              wr_addr_s     = wr_cmt_r[ADDR_WIDTH-1:0];
              wr_spec_nxt_s = wr_cmt_r + PW'(1);
              commit_s      = in_eop;
            end
          end else if (oversize_s) begin
            drop_s        = 1'b1;
            err_s         = 1'b1;
            wr_spec_nxt_s = wr_cmt_r;
          end else if (abort_s) begin
            drop_s        = 1'b1;
            wr_spec_nxt_s = wr_cmt_r;
          end else begin
            err_s         = in_sop;
            wr_en_s       = 1'b1;
            wr_spec_nxt_s = wr_spec_r + PW'(1);
            commit_s      = in_eop;
          end
        end
        ST_DISCARD: begin
          wr_en_s = 1'b0;
        end
        default: begin
          wr_en_s = 1'b0;
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
    // Cut-through publishes every written beat; store-and-forward only on a clean EOP.
    if (commit_s || (!STORE_FWD && wr_en_s)) begin
      wr_cmt_nxt_s = wr_spec_nxt_s;
    end else begin
      wr_cmt_nxt_s = wr_cmt_r;
    end
  end

  // Beat storage; contents need no reset because pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= {in_hdr, in_data, in_sop, in_eop};
    end
  end

  // Pointer registers and registered event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_spec_r    <= {PW{1'b0}};
      wr_cmt_r     <= {PW{1'b0}};
      rd_r         <= {PW{1'b0}};
      drop_pulse_r <= 1'b0;
      err_pulse_r  <= 1'b0;
    end else begin
      wr_spec_r    <= wr_spec_nxt_s;
      wr_cmt_r     <= wr_cmt_nxt_s;
      rd_r         <= rd_fire_s ? (rd_r + PW'(1)) : rd_r;
      drop_pulse_r <= drop_s;
      err_pulse_r  <= err_s;
    end
  end

  // Count of published TLPs whose EOP has not yet been read out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count_r <= {PW{1'b0}};
    end else if (commit_s && !pop_eop_s) begin
      pkt_count_r <= pkt_count_r + PW'(1);
    end else if (!commit_s && pop_eop_s) begin
      pkt_count_r <= pkt_count_r - PW'(1);
    end else begin
      pkt_count_r <= pkt_count_r;
    end
  end

endmodule

// File: tb/tb_tlp_pkt_fifo.sv
// tb_tlp_pkt_fifo: directed bench for tlp_pkt_fifo. A store-and-forward and a cut-through
// instance share the stimulus; sel picks which one is driven and checked. A queue-based
// model of the FIFO contents is compared against the selected instance every cycle, and
// hand-computed literal checks pin the key behaviours.
module tb_tlp_pkt_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 128;
  localparam int HW    = 128;
  localparam int PW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic [DW-1:0] in_data  = '0;
  logic [HW-1:0] in_hdr   = '0;
  logic          in_valid = 1'b0;
  logic          in_sop   = 1'b0;
  logic          in_eop   = 1'b0;
  logic          in_abort = 1'b0;
  logic          out_ready = 1'b1;

  logic          sf_in_valid, ct_in_valid;
  logic          sf_in_ready, ct_in_ready;
  logic [DW-1:0] sf_out_data, ct_out_data;
  logic [HW-1:0] sf_out_hdr, ct_out_hdr;
  logic          sf_out_sop, ct_out_sop, sf_out_eop, ct_out_eop;
  logic          sf_out_valid, ct_out_valid;
  logic [PW-1:0] sf_level, ct_level, sf_pkt_count, ct_pkt_count;
  logic          sf_afull, ct_afull, sf_drop, ct_drop, sf_err, ct_err;

  logic          d_in_ready, d_out_valid, d_out_sop, d_out_eop, d_afull, d_drop, d_err;
  logic [DW-1:0] d_out_data;
  logic [HW-1:0] d_out_hdr;
  logic [PW-1:0] d_level, d_pkt_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sf_in_valid = in_valid && !sel;
  assign ct_in_valid = in_valid && sel;

  tlp_pkt_fifo #(.STORE_FWD(1'b1)) u_sf (
    .clk(clk), .rst(rst), .in_data(in_data), .in_hdr(in_hdr), .in_valid(sf_in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_abort(in_abort), .in_ready(sf_in_ready),
    .out_data(sf_out_data), .out_hdr(sf_out_hdr), .out_sop(sf_out_sop), .out_eop(sf_out_eop),
    .out_valid(sf_out_valid), .out_ready(out_ready), .level(sf_level), .pkt_count(sf_pkt_count),
    .almost_full(sf_afull), .drop_pulse(sf_drop), .err_pulse(sf_err)
  );

  tlp_pkt_fifo #(.STORE_FWD(1'b0)) u_ct (
    .clk(clk), .rst(rst), .in_data(in_data), .in_hdr(in_hdr), .in_valid(ct_in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_abort(in_abort), .in_ready(ct_in_ready),
    .out_data(ct_out_data), .out_hdr(ct_out_hdr), .out_sop(ct_out_sop), .out_eop(ct_out_eop),
    .out_valid(ct_out_valid), .out_ready(out_ready), .level(ct_level), .pkt_count(ct_pkt_count),
    .almost_full(ct_afull), .drop_pulse(ct_drop), .err_pulse(ct_err)
  );

  assign d_in_ready  = sel ? ct_in_ready  : sf_in_ready;
  assign d_out_valid = sel ? ct_out_valid : sf_out_valid;
  assign d_out_data  = sel ? ct_out_data  : sf_out_data;
  assign d_out_hdr   = sel ? ct_out_hdr   : sf_out_hdr;
  assign d_out_sop   = sel ? ct_out_sop   : sf_out_sop;
  assign d_out_eop   = sel ? ct_out_eop   : sf_out_eop;
  assign d_level     = sel ? ct_level     : sf_level;
  assign d_pkt_count = sel ? ct_pkt_count : sf_pkt_count;
  assign d_afull     = sel ? ct_afull     : sf_afull;
  assign d_drop      = sel ? ct_drop      : sf_drop;
  assign d_err       = sel ? ct_err       : sf_err;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t cq[$];        // beats visible to the consumer, in order
  beat_t pq[$];        // store-and-forward TLP still being assembled
  int    mst = 0;      // 0 between TLPs, 1 inside a TLP, 2 discarding
  logic  exp_drop = 1'b0;
  logic  exp_err  = 1'b0;

  function automatic int m_level();
    return cq.size() + pq.size();
  endfunction

  function automatic int m_pkts();
    int n = 0;
    foreach (cq[i]) if (cq[i].eop) n++;
    return n;
  endfunction

  function automatic logic m_in_ready();
    return !rst && ((mst == 2) || (m_level() < DEPTH));
  endfunction

  task automatic model_step();
    beat_t b;
    bit acc, fire, sf, ab, big;
    b    = {in_hdr, in_data, in_sop, in_eop};
    sf   = !sel;
    acc  = in_valid && m_in_ready();
    fire = (cq.size() > 0) && out_ready;
    big  = sf && (cq.size() == 0) && (pq.size() + 1 == DEPTH);
    ab   = sf && in_abort && in_eop;
    exp_drop = 1'b0;
    exp_err  = 1'b0;
    if (acc) begin
      if (mst == 2) begin
        if (in_eop) mst = 0;
      end else if (mst == 0 && !in_sop) begin
        exp_err = 1'b1;
      end else if (mst == 1 && !in_sop && big) begin
        exp_drop = 1'b1;
        exp_err  = 1'b1;
        pq.delete();
        mst = in_eop ? 0 : 2;
      end else begin
        if (mst == 1 && in_sop) begin
          exp_err = 1'b1;
          if (sf) pq.delete();
        end
        if (!sf) begin
          cq.push_back(b);
          mst = in_eop ? 0 : 1;
        end else if (in_eop) begin
          if (ab) exp_drop = 1'b1;
          else begin
            foreach (pq[i]) cq.push_back(pq[i]);
            cq.push_back(b);
          end
          pq.delete();
          mst = 0;
        end else begin
          pq.push_back(b);
          mst = 1;
        end
      end
    end
    if (fire) void'(cq.pop_front());
  endtask

  // Model advances on each clock edge and clears on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cq.delete();
      pq.delete();
      mst = 0;
      exp_drop = 1'b0;
      exp_err  = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the selected instance against the model.
  always @(negedge clk) begin
    cmp("in_ready", d_in_ready, m_in_ready());
    cmp("out_valid", d_out_valid, cq.size() > 0);
    if (cq.size() > 0) begin
      cmp("out_data", d_out_data, cq[0].data);
      cmp("out_hdr", d_out_hdr, cq[0].hdr);
      cmp("out_sop", d_out_sop, cq[0].sop);
      cmp("out_eop", d_out_eop, cq[0].eop);
    end
    cmp("level", d_level, m_level());
    cmp("pkt_count", d_pkt_count, m_pkts());
    cmp("almost_full", d_afull, m_level() >= 12);
    cmp("drop_pulse", d_drop, exp_drop);
    cmp("err_pulse", d_err, exp_err);
  end

  // ---------------- stimulus ----------------
  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic send(input int tag, input bit s, input bit e, input bit a);
    int n = 0;
    @(negedge clk);
    in_data  = DW'(tag);
    in_hdr   = ~(HW'(tag));
    in_sop   = s;
    in_eop   = e;
    in_abort = a;
    in_valid = 1'b1;
    while (!d_in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    cmp("send_ready", d_in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_abort = 1'b0;
  endtask

  task automatic do_reset(input logic s);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sel = s;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_in_ready", d_in_ready, 1'b0);
    cmp("rst_out_valid", d_out_valid, 1'b0);
    cmp("rst_level", d_level, 5'd0);
    rst = 1'b0;
    at_neg();
    cmp("post_rst_in_ready", d_in_ready, 1'b1);

    // 1: store-and-forward 3-beat TLP held until EOP commits
    out_ready = 1'b1;
    send(32'h101, 1'b1, 1'b0, 1'b0);
    at_neg();
    cmp("t1_hold_valid", d_out_valid, 1'b0);
    cmp("t1_level1", d_level, 5'd1);
    send(32'h102, 1'b0, 1'b0, 1'b0);
    send(32'h103, 1'b0, 1'b1, 1'b0);
    at_neg();
    cmp("t1_valid", d_out_valid, 1'b1);
    cmp("t1_d0", d_out_data, 128'h101);
    cmp("t1_d0_sop", d_out_sop, 1'b1);
    cmp("t1_pkt1", d_pkt_count, 5'd1);
    at_neg();
    cmp("t1_d1", d_out_data, 128'h102);
    at_neg();
    cmp("t1_d2", d_out_data, 128'h103);
    cmp("t1_d2_eop", d_out_eop, 1'b1);
    at_neg();
    cmp("t1_empty", d_out_valid, 1'b0);
    cmp("t1_pkt0", d_pkt_count, 5'd0);

    // 2: abort on EOP discards the TLP; the aborted EOP beat itself is never stored
    send(32'h201, 1'b1, 1'b0, 1'b0);
    send(32'h202, 1'b0, 1'b0, 1'b0);
    send(32'h203, 1'b0, 1'b0, 1'b0);
    at_neg();
    cmp("t2_level3", d_level, 5'd3);
    send(32'h204, 1'b0, 1'b1, 1'b1);
    at_neg();
    cmp("t2_drop", d_drop, 1'b1);
    cmp("t2_level0", d_level, 5'd0);
    cmp("t2_no_valid", d_out_valid, 1'b0);
    at_neg();
    cmp("t2_drop_clr", d_drop, 1'b0);

    // 3: fill with 16 single-beat TLPs, then refill across the pointer wrap
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      send(32'h300 + i, 1'b1, 1'b1, 1'b0);
      at_neg();
      cmp("t3_level", d_level, 128'(i));
      cmp("t3_afull", d_afull, i >= 12);
    end
    cmp("t3_full_ready", d_in_ready, 1'b0);
    cmp("t3_pkt16", d_pkt_count, 5'd16);
    out_ready = 1'b1;
    #1;
    cmp("t3_no_bypass", d_in_ready, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      send(32'h320 + i, 1'b1, 1'b1, 1'b0);
    end
    repeat (20) at_neg();
    cmp("t3_drained", d_out_valid, 1'b0);

    // 4: oversize 20-beat TLP dropped at beat 16, rest flushed, next TLP intact
    for (int i = 1; i <= 20; i++) begin
      send(32'h400 + i, i == 1, i == 20, 1'b0);
      if (i == 15) begin
        at_neg();
        cmp("t4_level15", d_level, 5'd15);
        cmp("t4_no_drop", d_drop, 1'b0);
      end
      if (i == 16) begin
        at_neg();
        cmp("t4_drop", d_drop, 1'b1);
        cmp("t4_err", d_err, 1'b1);
        cmp("t4_level0", d_level, 5'd0);
      end
    end
    send(32'h431, 1'b1, 1'b0, 1'b0);
    send(32'h432, 1'b0, 1'b1, 1'b0);
    at_neg();
    cmp("t4_next_valid", d_out_valid, 1'b1);
    cmp("t4_next_d0", d_out_data, 128'h431);
    repeat (3) at_neg();

    // 5: cut-through instance
    do_reset(1'b1);
    out_ready = 1'b0;
    send(32'h501, 1'b1, 1'b0, 1'b0);
    at_neg();
    cmp("t5_ct_valid", d_out_valid, 1'b1);
    cmp("t5_ct_d0", d_out_data, 128'h501);
    send(32'h502, 1'b0, 1'b0, 1'b0);
    send(32'h503, 1'b0, 1'b1, 1'b0);
    send(32'h5ff, 1'b0, 1'b0, 1'b0);
    at_neg();
    cmp("t5_orphan_err", d_err, 1'b1);
    cmp("t5_orphan_level", d_level, 5'd3);
    out_ready = 1'b1;
    repeat (5) at_neg();

    // 6: reset in the middle of a TLP clears everything at once
    do_reset(1'b0);
    out_ready = 1'b0;
    send(32'h601, 1'b1, 1'b1, 1'b0);
    send(32'h611, 1'b1, 1'b0, 1'b0);
    send(32'h612, 1'b0, 1'b0, 1'b0);
    at_neg();
    cmp("t6_level3", d_level, 5'd3);
    cmp("t6_pkt1", d_pkt_count, 5'd1);
    #2;
    rst = 1'b1;
    #1;
    cmp("t6_rst_valid", d_out_valid, 1'b0);
    cmp("t6_rst_level", d_level, 5'd0);
    cmp("t6_rst_pkt", d_pkt_count, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h621, 1'b1, 1'b0, 1'b0);
    send(32'h622, 1'b0, 1'b1, 1'b0);
    at_neg();
    cmp("t6_after_valid", d_out_valid, 1'b1);
    cmp("t6_after_d0", d_out_data, 128'h621);
    repeat (4) at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
